// File: rtl/dispatch_pkg.sv
// Shared constants, entry layout and width helpers for the priority dispatcher.
package dispatch_pkg;

    localparam int N_DEF     = 8;
    localparam int DW_DEF    = 32;
    localparam int PW_DEF    = 3;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic [PW_DEF-1:0] prioity;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Index width for a power-of-two range; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Single-clock FIFO with occupancy count; one instance per dispatcher channel.
module dispatch_fifo
    import dispatch_pkg::*;
#(
    parameter int W     = ENTRY_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int PTRW = ptr_width(DEPTH);
    localparam int CW   = cnt_width(DEPTH);

    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Guards make the FIFO safe on its own; the dispatcher never violates them.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/prio_dispatcher.sv
// Demultiplexes one valid/ready stream onto N independently buffered channels,
// so a stalled consumer only backs up traffic addressed to itself.
module prio_dispatcher
    import dispatch_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int PW    = PW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_i,
    input  logic [DW-1:0]                     data_i,
    input  logic [PW-1:0]                     prioity_i,
    input  logic [ptr_width(N)-1:0]           dest_i,
    output logic                              ready_i,
    output logic [N-1:0]                      valid_o,
    output logic [N*DW-1:0]                   data_o,
    output logic [N*PW-1:0]                   prioity_o,
    input  logic [N-1:0]                      ready_o,
    output logic [N*cnt_width(DEPTH)-1:0]     count_o
);

    localparam int EW    = DW + PW;
    localparam int CW    = cnt_width(DEPTH);
    localparam int DESTW = ptr_width(N);

    logic [N-1:0]  full;
    logic [N-1:0]  empty;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic [EW-1:0] wdata;
    logic          accept;

    // ready_i depends only on dest_i and registered occupancy, never on ready_o.
    assign ready_i = !full[dest_i];
    assign accept  = valid_i && ready_i;
    assign wdata   = {data_i, prioity_i};
    assign valid_o = ~empty;
    assign pop     = valid_o & ready_o;

    for (genvar k = 0; k < N; k++) begin : g_chan
        logic [EW-1:0] rdata;
        logic [CW-1:0] count;

        assign push[k] = accept && (dest_i == DESTW'(k));

        dispatch_fifo #(
            .W     (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[k]),
            .wdata (wdata),
            .pop   (pop[k]),
            .rdata (rdata),
            .full  (full[k]),
            .empty (empty[k]),
            .count (count)
        );

        assign data_o[k*DW +: DW]    = rdata[EW-1:PW];
        assign prioity_o[k*PW +: PW] = rdata[PW-1:0];
        assign count_o[k*CW +: CW]   = count;
    end

endmodule

// File: tb/tb_prio_dispatcher.sv
// Directed and randomized checks of the per-channel dispatcher.
module tb_prio_dispatcher;
    import dispatch_pkg::*;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int PW    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int EW    = DW + PW;

    logic              clk;
    logic              reset;
    logic              valid_i;
    logic [DW-1:0]     data_i;
    logic [PW-1:0]     prioity_i;
    logic [2:0]        dest_i;
    logic              ready_i;
    logic [N-1:0]      valid_o;
    logic [N*DW-1:0]   data_o;
    logic [N*PW-1:0]   prioity_o;
    logic [N-1:0]      ready_o;
    logic [N*CW-1:0]   count_o;

    int tests;
    int fails;

    prio_dispatcher #(.N(N), .DW(DW), .PW(PW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .prioity_i (prioity_i),
        .dest_i    (dest_i),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .prioity_o (prioity_o),
        .ready_o   (ready_o),
        .count_o   (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dslice(input int k);
        return data_o[k*DW +: DW];
    endfunction

    function automatic logic [PW-1:0] pslice(input int k);
        return prioity_o[k*PW +: PW];
    endfunction

    function automatic logic [CW-1:0] cslice(input int k);
        return count_o[k*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] d, input logic [DW-1:0] dat, input logic [PW-1:0] p);
        valid_i   = v;
        dest_i    = d;
        data_i    = dat;
        prioity_i = p;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 3'd0, '0, '0);
        ready_o = '0;
        step();
        step();
        tests++; if (valid_o !== 8'h00) begin fails++; $display("FAIL reset_valid: got %h expected %h", valid_o, 8'h00); end
        tests++; if (count_o !== '0) begin fails++; $display("FAIL reset_count: got %h expected 0", count_o); end
        tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready_i); end
        reset = 1'b0;
        step();
        tests++; if (valid_o !== 8'h00) begin fails++; $display("FAIL post_reset_valid: got %h expected %h", valid_o, 8'h00); end
    endtask

    task automatic test_single();
        drive(1'b1, 3'd3, 32'hA5A5_0001, 3'd5);
        #1;
        tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL single_ready: got %b expected 1", ready_i); end
        step();
        drive(1'b0, 3'd0, '0, '0);
        tests++; if (valid_o !== 8'h08) begin fails++; $display("FAIL single_valid: got %h expected %h", valid_o, 8'h08); end
        tests++; if (dslice(3) !== 32'hA5A5_0001) begin fails++; $display("FAIL single_data: got %h expected %h", dslice(3), 32'hA5A5_0001); end
        tests++; if (pslice(3) !== 3'd5) begin fails++; $display("FAIL single_prio: got %0d expected 5", pslice(3)); end
        tests++; if (cslice(3) !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", cslice(3)); end
        ready_o[3] = 1'b1;
        step();
        tests++; if (valid_o !== 8'h00) begin fails++; $display("FAIL single_drain: got %h expected %h", valid_o, 8'h00); end
        tests++; if (cslice(3) !== 3'd0) begin fails++; $display("FAIL single_drain_count: got %0d expected 0", cslice(3)); end
        ready_o = '0;
    endtask

    task automatic test_full();
        ready_o = '0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd2, 32'h10 + i, PW'(i));
            #1;
            tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, ready_i); end
            step();
        end
        drive(1'b1, 3'd2, 32'h14, 3'd4);
        #1;
        tests++; if (ready_i !== 1'b0) begin fails++; $display("FAIL full_ready: got %b expected 0", ready_i); end
        tests++; if (cslice(2) !== 3'd4) begin fails++; $display("FAIL full_count: got %0d expected 4", cslice(2)); end
        drive(1'b1, 3'd5, 32'h55, 3'd7);
        #1;
        tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL other_ready: got %b expected 1", ready_i); end
        step();
        drive(1'b0, 3'd0, '0, '0);
        tests++; if (valid_o !== 8'h24) begin fails++; $display("FAIL full_valid: got %h expected %h", valid_o, 8'h24); end
        tests++; if (cslice(2) !== 3'd4) begin fails++; $display("FAIL full_count_hold: got %0d expected 4", cslice(2)); end
        tests++; if (cslice(5) !== 3'd1) begin fails++; $display("FAIL other_count: got %0d expected 1", cslice(5)); end
        tests++; if (dslice(5) !== 32'h55) begin fails++; $display("FAIL other_data: got %h expected %h", dslice(5), 32'h55); end
        tests++; if (pslice(5) !== 3'd7) begin fails++; $display("FAIL other_prio: got %0d expected 7", pslice(5)); end
        ready_o[5] = 1'b1;
        step();
        ready_o[5] = 1'b0;
        tests++; if (valid_o[5] !== 1'b0) begin fails++; $display("FAIL other_drain: got %b expected 0", valid_o[5]); end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] exp_seq [5];
        exp_seq = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
        drive(1'b1, 3'd2, 32'h14, 3'd4);
        ready_o[2] = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            tests++; if (valid_o[2] !== 1'b1) begin fails++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, valid_o[2]); end
            tests++; if (dslice(2) !== exp_seq[i]) begin fails++; $display("FAIL drain_data[%0d]: got %h expected %h", i, dslice(2), exp_seq[i]); end
            if (i == 0) begin
                tests++; if (ready_i !== 1'b0) begin fails++; $display("FAIL pop_full_ready: got %b expected 0", ready_i); end
            end
            if (i == 1) begin
                tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL pop_next_ready: got %b expected 1", ready_i); end
            end
            if (i == 4) begin
                tests++; if (pslice(2) !== 3'd4) begin fails++; $display("FAIL drain_prio: got %0d expected 4", pslice(2)); end
            end
            step();
            if (i == 1) drive(1'b0, 3'd0, '0, '0);
        end
        tests++; if (valid_o[2] !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", valid_o[2]); end
        ready_o = '0;
    endtask

    task automatic test_stream();
        ready_o = '0;
        ready_o[6] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd6, 32'h600 + i, PW'(i));
            step();
            tests++; if (valid_o[6] !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, valid_o[6]); end
            tests++; if (dslice(6) !== 32'h600 + i) begin fails++; $display("FAIL stream_data[%0d]: got %h expected %h", i, dslice(6), 32'h600 + i); end
            tests++; if (cslice(6) !== 3'd1) begin fails++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, cslice(6)); end
        end
        drive(1'b0, 3'd0, '0, '0);
        step();
        tests++; if (valid_o !== 8'h00) begin fails++; $display("FAIL stream_end: got %h expected %h", valid_o, 8'h00); end
        ready_o = '0;
    endtask

    typedef logic [EW-1:0] ent_q_t [$];

    task automatic test_random();
        ent_q_t q [N];
        int sent;
        int cyc;
        logic go;
        logic [2:0] d;
        logic [PW-1:0] p;
        logic exp_ready;
        logic [EW-1:0] head;
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || q[0].size() + q[1].size() + q[2].size() + q[3].size() +
                q[4].size() + q[5].size() + q[6].size() + q[7].size() != 0) && cyc < 20000) begin
            ready_o = (sent < 1000) ? N'($urandom) : '1;
            go = (sent < 1000) && ($urandom_range(0, 3) != 0);
            d  = 3'($urandom_range(0, 7));
            p  = PW'($urandom_range(0, 7));
            drive(go, d, 32'h1000_0000 + sent, p);
            #1;
            exp_ready = (q[d].size() < DEPTH);
            tests++; if (ready_i !== exp_ready) begin fails++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, ready_i, exp_ready); end
            for (int k = 0; k < N; k++) begin
                tests++; if (valid_o[k] !== (q[k].size() != 0)) begin fails++; $display("FAIL rand_valid ch%0d cyc %0d: got %b expected %b", k, cyc, valid_o[k], q[k].size() != 0); end
                tests++; if (cslice(k) !== CW'(q[k].size())) begin fails++; $display("FAIL rand_count ch%0d cyc %0d: got %0d expected %0d", k, cyc, cslice(k), q[k].size()); end
                if (q[k].size() != 0 && ready_o[k]) begin
                    head = q[k].pop_front();
                    tests++; if ({dslice(k), pslice(k)} !== head) begin fails++; $display("FAIL rand_head ch%0d cyc %0d: got %h/%0d expected %h/%0d", k, cyc, dslice(k), pslice(k), head[EW-1:PW], head[PW-1:0]); end
                end
            end
            if (go && exp_ready) begin
                q[d].push_back({32'h1000_0000 + sent, p});
                sent++;
            end
            step();
            cyc++;
        end
        tests++; if (cyc >= 20000) begin fails++; $display("FAIL rand_timeout: got %0d cycles, sent %0d expected 1000 delivered", cyc, sent); end
        drive(1'b0, 3'd0, '0, '0);
        ready_o = '0;
        step();
        tests++; if (valid_o !== 8'h00) begin fails++; $display("FAIL rand_leftover: got %h expected %h", valid_o, 8'h00); end
    endtask

    task automatic test_reset_mid();
        ready_o = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd1, 32'h700 + i, 3'd1);
            step();
        end
        drive(1'b0, 3'd0, '0, '0);
        tests++; if (cslice(1) !== 3'd3) begin fails++; $display("FAIL mid_preload: got %0d expected 3", cslice(1)); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (valid_o !== 8'h00) begin fails++; $display("FAIL mid_reset_valid: got %h expected %h", valid_o, 8'h00); end
        tests++; if (count_o !== '0) begin fails++; $display("FAIL mid_reset_count: got %h expected 0", count_o); end
        tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b expected 1", ready_i); end
        step();
        reset = 1'b0;
        step();
        drive(1'b1, 3'd1, 32'h0000_BEEF, 3'd2);
        step();
        drive(1'b0, 3'd0, '0, '0);
        tests++; if (valid_o !== 8'h02) begin fails++; $display("FAIL after_reset_valid: got %h expected %h", valid_o, 8'h02); end
        tests++; if (dslice(1) !== 32'h0000_BEEF) begin fails++; $display("FAIL after_reset_data: got %h expected %h", dslice(1), 32'h0000_BEEF); end
        tests++; if (cslice(1) !== 3'd1) begin fails++; $display("FAIL after_reset_count: got %0d expected 1", cslice(1)); end
        ready_o[1] = 1'b1;
        step();
        tests++; if (valid_o !== 8'h00) begin fails++; $display("FAIL after_reset_drain: got %h expected %h", valid_o, 8'h00); end
        ready_o = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_full();
        test_full_pop();
        test_stream();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
